// File: rtl/dco_sweep_ctrl.sv
// Steps a DCO tuning word from f_start toward f_stop, holding each word for dwell+1 cycles, clamped at f_stop.
// All outputs registered; no backpressure, abort and reset return to IDLE on the next edge.
module dco_sweep_ctrl #(
    parameter int N = 5,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] f_start,
    input  logic [N-1:0] f_stop,
    input  logic [N-1:0] f_step,
    input  logic [D-1:0] dwell,
    output logic [N-1:0] inc,
    output logic         dco_clr,
    output logic         dco_en,
    output logic         busy,
    output logic         done,
    output logic         step_strobe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state;
    logic [N-1:0] start_q;
    logic [N-1:0] stop_q;
    logic [N-1:0] step_q;
    logic [D-1:0] dwell_q;
    logic [D-1:0] cnt;
    logic         up_q;

    logic [N-1:0] step_eff;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] next_word;

    // One extra bit catches both overflow past full scale and borrow below zero,
    // so either case clamps to the stop word instead of wrapping.
    always_comb begin
        step_eff  = step_q;
        if (step_q == '0) begin
            step_eff = N'(1);
        end
        sum       = {1'b0, inc} + {1'b0, step_eff};
        diff      = {1'b0, inc} - {1'b0, step_eff};
        next_word = stop_q;
        if (up_q) begin
            if (sum < {1'b0, stop_q}) begin
                next_word = sum[N-1:0];
            end
        end else begin
            if (!diff[N] && (diff[N-1:0] > stop_q)) begin
                next_word = diff[N-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            inc         <= '0;
            cnt         <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            up_q        <= 1'b0;
            dco_clr     <= 1'b0;
            dco_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_strobe <= 1'b0;
        end else if (abort && ((state == LOAD) || (state == DWELL))) begin
            state       <= IDLE;
            inc         <= '0;
            cnt         <= '0;
            dco_clr     <= 1'b0;
            dco_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            done        <= 1'b0;
            step_strobe <= 1'b0;
            dco_clr     <= 1'b0;
            case (state)
                IDLE: begin
                    inc    <= '0;
                    dco_en <= 1'b0;
                    busy   <= 1'b0;
                    if (start && !abort) begin
                        start_q <= f_start;
                        stop_q  <= f_stop;
                        step_q  <= f_step;
                        dwell_q <= dwell;
                        up_q    <= (f_stop > f_start);
                        dco_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    inc    <= start_q;
                    cnt    <= dwell_q;
                    dco_en <= 1'b1;
                    busy   <= 1'b1;
                    state  <= DWELL;
                end
                DWELL: begin
                    if (cnt == '0) begin
                        if (inc == stop_q) begin
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            dco_en <= 1'b0;
                            state  <= DONE;
                        end else begin
                            inc         <= next_word;
                            cnt         <= dwell_q;
                            step_strobe <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - D'(1);
                    end
                end
                DONE: begin
                    inc   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dco_sweep_ctrl.sv
// Directed sweeps with hand-listed tuning-word sequences; expected per-cycle records are queued and checked by a separate monitor.
module tb_dco_sweep_ctrl;
    localparam int N = 5;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [N-1:0] f_start, f_stop, f_step;
    logic [D-1:0] dwell;
    logic [N-1:0] inc;
    logic         dco_clr, dco_en, busy, done, step_strobe;

    dco_sweep_ctrl #(.N(N), .D(D)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .inc(inc), .dco_clr(dco_clr), .dco_en(dco_en), .busy(busy),
        .done(done), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] inc;
        logic         clr;
        logic         en;
        logic         busy;
        logic         done;
        logic         strobe;
    } rec_t;

    rec_t         exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    string        tag = "reset";
    logic [N-1:0] words [8];

    function automatic rec_t mk(input logic [N-1:0] w, input logic c, input logic e,
                                input logic b, input logic d, input logic s);
        rec_t r;
        r.inc = w; r.clr = c; r.en = e; r.busy = b; r.done = d; r.strobe = s;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("inc=%0d clr=%b en=%b busy=%b done=%b strobe=%b",
                         r.inc, r.clr, r.en, r.busy, r.done, r.strobe);
    endfunction

    function automatic rec_t cur();
        return mk(inc, dco_clr, dco_en, busy, done, step_strobe);
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %s, want %s", tag, name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_idle(input string name);
        check(name, cur(), mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Monitor: every active output cycle consumes one expected record.
    always @(negedge clk) begin
        if (busy === 1'b1 || done === 1'b1 || dco_en === 1'b1 ||
            dco_clr === 1'b1 || step_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s/unexpected_activity: got %s, want idle", tag, fmt(cur()));
            end else begin
                check("sweep_cycle", cur(), exp_q.pop_front());
            end
        end
    end

    // Expands the hand-listed word sequence into one record per cycle.
    task automatic issue(input logic [N-1:0] s, input logic [N-1:0] e, input logic [N-1:0] st,
                         input logic [D-1:0] dw, input int nw);
        @(negedge clk);
        f_start = s; f_stop = e; f_step = st; dwell = dw; start = 1'b1;
        exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < nw; k++) begin
            for (int c = 0; c <= int'(dw); c++) begin
                exp_q.push_back(mk(words[k], 1'b0, 1'b1, 1'b1, 1'b0, (k > 0) && (c == 0)));
            end
        end
        exp_q.push_back(mk(words[nw-1], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_sweep();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s/drain_timeout: got %0d records left, want 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check_idle("idle_after_done");
    endtask

    task automatic check_left(input int want);
        n_vec++;
        if (exp_q.size() != want) begin
            n_err++;
            $display("FAIL %s/records_consumed: got %0d left, want %0d", tag, exp_q.size(), want);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_priority");
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");

        tag = "up";
        words[0] = 5'd4; words[1] = 5'd8; words[2] = 5'd12;
        issue(5'd4, 5'd12, 5'd4, 8'd2, 3);
        finish_sweep();

        tag = "down_clamp";
        words[0] = 5'd20; words[1] = 5'd12; words[2] = 5'd4; words[3] = 5'd3;
        issue(5'd20, 5'd3, 5'd8, 8'd0, 4);
        finish_sweep();

        tag = "up_clamp_full_scale";
        words[0] = 5'd28; words[1] = 5'd31;
        issue(5'd28, 5'd31, 5'd6, 8'd1, 2);
        finish_sweep();

        tag = "single_word";
        words[0] = 5'd9;
        issue(5'd9, 5'd9, 5'd5, 8'd3, 1);
        finish_sweep();

        tag = "zero_step";
        words[0] = 5'd2; words[1] = 5'd3; words[2] = 5'd4;
        issue(5'd2, 5'd4, 5'd0, 8'd0, 3);
        finish_sweep();

        tag = "abort";
        words[0] = 5'd4; words[1] = 5'd8; words[2] = 5'd12;
        issue(5'd4, 5'd12, 5'd4, 8'd2, 3);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_left(8);
        check_idle("idle_after_abort");
        repeat (3) @(negedge clk);
        check_idle("no_done_after_abort");

        tag = "reset_mid";
        issue(5'd4, 5'd12, 5'd4, 8'd2, 3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_left(8);
        check_idle("idle_after_reset");
        repeat (3) @(negedge clk);
        check_idle("no_done_after_reset");

        tag = "start_with_abort";
        @(negedge clk);
        f_start = 5'd1; f_stop = 5'd6; f_step = 5'd1; dwell = 8'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check_idle("no_load");
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("still_idle");

        tag = "midsweep_changes";
        words[0] = 5'd4; words[1] = 5'd8; words[2] = 5'd12;
        issue(5'd4, 5'd12, 5'd4, 8'd2, 3);
        @(negedge clk);
        f_stop = 5'd8; f_start = 5'd0; f_step = 5'd1; dwell = 8'd0; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        finish_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dco_sweep_ctrl.md
DCO_SWEEP_CTRL -- requirements
Module: dco_sweep_ctrl

Interface
REQ-001 SHALL have parameter N, default 5, meaning the DCO accumulator and tuning-word width.
REQ-002 SHALL have parameter D, default 8, meaning the dwell-counter width.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit, meaning a sweep request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit, meaning terminate the sweep immediately.
REQ-007 SHALL have ports f_start, f_stop and f_step, all inputs, N bits each, meaning the first tuning word, the last tuning word and the step magnitude.
REQ-008 SHALL have port dwell, input, D bits, meaning each tuning word is held for dwell+1 cycles.
REQ-009 SHALL have port inc, output, N bits, meaning the tuning word driven to the DCO.
REQ-010 SHALL have port dco_clr, output, 1 bit, meaning the DCO phase-accumulator clear.
REQ-011 SHALL have port dco_en, output, 1 bit, meaning the DCO accumulate enable.
REQ-012 SHALL have port busy, output, 1 bit, meaning high in LOAD and DWELL.
REQ-013 SHALL have port done, output, 1 bit, meaning a 1-cycle pulse at normal sweep completion.
REQ-014 SHALL have port step_strobe, output, 1 bit, meaning a 1-cycle pulse in the first cycle of each new tuning word after the first.

Function
REQ-015 SHALL register all outputs and implement the FSM states IDLE, LOAD, DWELL and DONE.
REQ-016 SHALL, in IDLE with start=1 and abort=0, latch f_start, f_stop, f_step and dwell, then enter LOAD; the latched values are immune to later input changes.
REQ-017 SHALL, in LOAD (1 cycle), drive dco_clr=1 and dco_en=0, then load inc=f_start and cnt=dwell and enter DWELL.
REQ-018 SHALL, in DWELL, drive dco_en=1, hold inc and decrement cnt each cycle.
REQ-019 SHALL, in DWELL when cnt==0 and inc==f_stop, enter DONE.
REQ-020 SHALL, in DWELL when cnt==0 and inc!=f_stop, load inc=next, cnt=dwell and step_strobe=1 for the next cycle.
REQ-021 SHALL sweep up when f_stop>f_start and down when f_stop<f_start.
REQ-022 SHALL compute next in N+1 bits and clamp it to f_stop, with no overshoot and no modulo wrap.
REQ-023 SHALL treat f_step=0 as a step of 1.
REQ-024 SHALL, when f_start==f_stop, hold a single word for dwell+1 cycles and then enter DONE.
REQ-025 SHALL, in DONE (1 cycle), drive done=1, busy=0 and dco_en=0 with inc holding its final value, then enter IDLE.
REQ-026 SHALL, in IDLE, drive inc=0, dco_en=0, dco_clr=0 and busy=0.
REQ-027 SHALL, on abort=1 in LOAD or DWELL, enter IDLE next cycle with no done pulse; abort has priority over all other transitions.
REQ-028 SHALL ignore start when busy=1, in DONE, or in the same cycle as abort.

Reset
REQ-029 SHALL, on reset=1 at a clock edge in any state, enter IDLE on that edge with inc=0 and all 1-bit outputs at 0.
REQ-030 SHALL, on reset mid-sweep, produce no done pulse and discard the latched configuration.
REQ-031 SHALL give reset priority over abort and start.

Verification
REQ-032 SHALL cover an up sweep: N=5, f_start=4, f_stop=12, f_step=4, dwell=2 -> LOAD 1 cycle, then inc 4,8,12 for 3 cycles each, busy high 10 cycles, step_strobe 2 pulses, then done 1 pulse.
REQ-033 SHALL cover a down sweep with clamp: f_start=20, f_stop=3, f_step=8, dwell=0 -> inc 20,12,4,3 for 1 cycle each, then done.
REQ-034 SHALL cover an up clamp near full scale: f_start=28, f_stop=31, f_step=6, dwell=1 -> inc 28,31 for 2 cycles each, with no wrap to 2.
REQ-035 SHALL cover the degenerate cases: f_start=f_stop=9, dwell=3 -> inc=9 for 4 cycles, 0 strobes, then done; separately f_start=2, f_stop=4, f_step=0 -> inc 2,3,4.
REQ-036 SHALL cover abort and reset: abort in the 2nd DWELL cycle -> next cycle IDLE, inc=0, dco_en=0, no done; repeat using reset=1 -> same response; start with abort the same cycle -> no sweep.
REQ-037 SHALL cover start and f_stop changes mid-sweep -> no restart and an unchanged inc sequence.
